// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_pkg
// Purpose  : Shared constants, clamp rules and helpers for prog_clock_divider.
// Revision : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    localparam int DIV_W_DEFAULT  = 8;
    localparam int DIV_STOP       = 0;
    localparam int DIV_CLAMP_FROM = 1;
    localparam int DIV_MIN_RUN    = 2;
    localparam int HIGH_MIN       = 1;

    // What a channel does on the coming edge.
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_LOAD    = 2'd1,
        ACT_RESTART = 2'd2,
        ACT_COUNT   = 2'd3
    } ch_action_e;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int clamp_div(input int d);
        return (d == DIV_CLAMP_FROM) ? DIV_MIN_RUN : d;
    endfunction

    function automatic int default_high(input int d);
        return (d > 0) ? ((d - 1) / 2 + 1) : HIGH_MIN;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_channel.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_channel
// Purpose  : One divider channel with boundary-aligned divisor updates.
//            Programmable high-time when CLKDIV_DUTY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEFAULT,
    parameter int RESET_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wr_div,
`ifdef CLKDIV_DUTY_EN
    input  logic [DIV_W-1:0] i_wr_high,
`endif
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pending
);

    localparam int               c_RST_DIV_I = clamp_div(RESET_DIV);
    localparam logic [DIV_W-1:0] c_RST_DIV   = DIV_W'(c_RST_DIV_I);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_pdiv;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;

    logic [DIV_W-1:0] w_new_div;
    logic [DIV_W-1:0] w_div_m1;
    logic [DIV_W-1:0] w_high_m1;
    logic             w_running;
    logic             w_wrap;
    logic             w_start;
    ch_action_e       w_act;

    assign w_new_div = (i_wr_div == DIV_W'(DIV_CLAMP_FROM)) ? DIV_W'(DIV_MIN_RUN) : i_wr_div;
    assign w_div_m1  = r_div - DIV_W'(1);
    assign w_running = (r_div >= DIV_W'(DIV_MIN_RUN));
    assign w_wrap    = w_running && (r_cnt == w_div_m1);
    // A restart only produces a pulse if the divisor it lands on is non-zero.
    assign w_start   = !r_pend || (r_pdiv != DIV_W'(DIV_STOP));

`ifdef CLKDIV_DUTY_EN
    localparam logic [DIV_W-1:0] c_RST_HIGH = DIV_W'(default_high(c_RST_DIV_I));

    logic [DIV_W-1:0] r_high;
    logic [DIV_W-1:0] r_phigh;
    logic [DIV_W-1:0] w_new_high;

    always_comb begin
        w_new_high = i_wr_high;
        if (i_wr_high == '0) begin
            w_new_high = DIV_W'(HIGH_MIN);
        end else if (i_wr_high >= w_new_div) begin
            w_new_high = w_new_div - DIV_W'(1);
        end
    end

    assign w_high_m1 = r_high - DIV_W'(1);
`else
    assign w_high_m1 = w_div_m1 >> 1;
`endif

    always_comb begin
        w_act = ACT_HOLD;
        if (!w_running) begin
            w_act = r_pend ? ACT_LOAD : ACT_HOLD;
        end else if (w_wrap || i_sync) begin
            w_act = ACT_RESTART;
        end else begin
            w_act = ACT_COUNT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= c_RST_DIV;
            r_cnt   <= '0;
            r_pdiv  <= '0;
            r_pend  <= 1'b0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
`ifdef CLKDIV_DUTY_EN
            r_high  <= c_RST_HIGH;
            r_phigh <= '0;
`endif
        end else begin
            // Acceptance requires r_pend low, so it never collides with an apply.
            if (i_wr) begin
                r_pend  <= 1'b1;
                r_pdiv  <= w_new_div;
`ifdef CLKDIV_DUTY_EN
                r_phigh <= w_new_high;
`endif
            end
            case (w_act)
                ACT_LOAD, ACT_RESTART: begin
                    r_cnt  <= '0;
                    r_clk  <= w_start;
                    r_tick <= w_start;
                    if (r_pend) begin
                        r_pend <= 1'b0;
                        r_div  <= r_pdiv;
`ifdef CLKDIV_DUTY_EN
                        r_high <= r_phigh;
`endif
                    end
                end
                ACT_COUNT: begin
                    r_cnt  <= r_cnt + DIV_W'(1);
                    r_tick <= 1'b0;
                    if (r_cnt == w_high_m1) begin
                        r_clk <= 1'b0;
                    end
                end
                default: begin
                    r_cnt  <= '0;
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                end
            endcase
        end
    end

    assign o_clk     = r_clk;
    assign o_tick    = r_tick;
    assign o_pending = r_pend;

endmodule
`default_nettype wire

// File: rtl/prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider
// Purpose  : NUM_CH programmable clock dividers with shared config port and
//            phase sync. Define CLKDIV_DUTY_EN for per-channel high-time.
// Revision : 1.0 - initial release
// ============================================================================
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = DIV_W_DEFAULT,
    parameter int RESET_DIV = 4
) (
    input  logic                          inClock,
    input  logic                          reset,
    input  logic                          syncIn,
    input  logic                          cfgValid,
    output logic                          cfgReady,
    input  logic [ch_idx_w(NUM_CH)-1:0]   cfgChannel,
    input  logic [DIV_W-1:0]              cfgDivider,
`ifdef CLKDIV_DUTY_EN
    input  logic [DIV_W-1:0]              cfgHigh,
`endif
    output logic [NUM_CH-1:0]             outClock,
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             pending
);

    localparam int c_CH_W  = ch_idx_w(NUM_CH);
    localparam int c_PAD_W = 1 << c_CH_W;

    logic [c_PAD_W-1:0] w_pend_pad;
    logic [NUM_CH-1:0]  w_wr;
    logic               w_accept;

    // Unused indices read as "not pending", so out-of-range writes are taken and dropped.
    assign w_pend_pad = c_PAD_W'(pending);
    assign cfgReady   = !w_pend_pad[cfgChannel];
    assign w_accept   = cfgValid && cfgReady;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_wr[i] = w_accept && (cfgChannel == c_CH_W'(i));

            clkdiv_channel #(
                .DIV_W     (DIV_W),
                .RESET_DIV (RESET_DIV)
            ) u_channel (
                .clk       (inClock),
                .rst       (reset),
                .i_sync    (syncIn),
                .i_wr      (w_wr[i]),
                .i_wr_div  (cfgDivider),
`ifdef CLKDIV_DUTY_EN
                .i_wr_high (cfgHigh),
`endif
                .o_clk     (outClock[i]),
                .o_tick    (tick[i]),
                .o_pending (pending[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_clock_divider
// Purpose  : Self-checking bench: directed vector table, hand sequences and a
//            random phase compared with a period/phase reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prog_clock_divider;

    localparam int NUM_CH    = 4;
    localparam int DIV_W     = 8;
    localparam int RESET_DIV = 4;
    localparam int CH_W      = 2;

    logic              inClock;
    logic              reset;
    logic              syncIn;
    logic              cfgValid;
    logic              cfgReady;
    logic [CH_W-1:0]   cfgChannel;
    logic [DIV_W-1:0]  cfgDivider;
    logic [DIV_W-1:0]  cfgHigh;
    logic [NUM_CH-1:0] outClock;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    prog_clock_divider #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .RESET_DIV  (RESET_DIV)
    ) dut (
        .inClock    (inClock),
        .reset      (reset),
        .syncIn     (syncIn),
        .cfgValid   (cfgValid),
        .cfgReady   (cfgReady),
        .cfgChannel (cfgChannel),
        .cfgDivider (cfgDivider),
`ifdef CLKDIV_DUTY_EN
        .cfgHigh    (cfgHigh),
`endif
        .outClock   (outClock),
        .tick       (tick),
        .pending    (pending)
    );

    initial inClock = 1'b0;
    always #5 inClock = ~inClock;

    int checks = 0;
    int errors = 0;

    // Reference model: period length, phase within the period, pending update.
    int m_d[NUM_CH];
    int m_h[NUM_CH];
    int m_c[NUM_CH];
    bit m_live[NUM_CH];
    bit m_tk[NUM_CH];
    bit m_pend[NUM_CH];
    int m_pd[NUM_CH];
    int m_ph[NUM_CH];

    typedef struct {
        bit v;
        int div;
        bit rdy;
        bit o;
        bit t;
        bit p;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_high(input int d, input int h);
`ifdef CLKDIV_DUTY_EN
        if (h == 0) return 1;
        if (h >= d) return d - 1;
        return h;
`else
        return (d - 1) / 2 + 1;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_d[i]    = (RESET_DIV == 1) ? 2 : RESET_DIV;
            m_h[i]    = (m_d[i] - 1) / 2 + 1;
            m_c[i]    = 0;
            m_live[i] = 0;
            m_tk[i]   = 0;
            m_pend[i] = 0;
            m_pd[i]   = 0;
            m_ph[i]   = 0;
        end
    endtask

    task automatic model_apply(input int i);
        m_d[i]    = m_pd[i];
        m_h[i]    = eff_high(m_pd[i], m_ph[i]);
        m_pend[i] = 0;
    endtask

    task automatic model_step(input bit s, input bit v, input int ch, input int dv, input int hi);
        bit wr;
        wr = v && (ch < NUM_CH) && !m_pend[ch];
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_d[i] == 0) begin
                m_c[i] = 0; m_live[i] = 0; m_tk[i] = 0;
                if (m_pend[i]) begin
                    model_apply(i);
                    m_live[i] = (m_d[i] != 0);
                    m_tk[i]   = (m_d[i] != 0);
                end
            end else if (s || m_c[i] == m_d[i] - 1) begin
                m_c[i] = 0; m_live[i] = 1; m_tk[i] = 1;
                if (m_pend[i]) begin
                    model_apply(i);
                    if (m_d[i] == 0) begin
                        m_live[i] = 0; m_tk[i] = 0;
                    end
                end
            end else begin
                m_c[i]++;
                m_tk[i] = 0;
            end
        end
        if (wr) begin
            m_pend[ch] = 1;
            m_pd[ch]   = (dv == 1) ? 2 : dv;
            m_ph[ch]   = hi;
        end
    endtask

    // One clock: drive, check ready, step model at the edge, check outputs after it.
    task automatic cycle(input bit s, input bit v, input int ch, input int dv, input int hi,
                         output logic rdy);
        logic [NUM_CH-1:0] eo, et, ep;
        syncIn     = s;
        cfgValid   = v;
        cfgChannel = CH_W'(ch);
        cfgDivider = DIV_W'(dv);
        cfgHigh    = DIV_W'(hi);
        #1;
        rdy = cfgReady;
        chk("cfgReady", {31'd0, cfgReady}, (ch >= NUM_CH) ? 32'd1 : {31'd0, !m_pend[ch]});
        @(posedge inClock);
        model_step(s, v, ch, dv, hi);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            eo[i] = m_live[i] && (m_c[i] < m_h[i]);
            et[i] = m_tk[i];
            ep[i] = m_pend[i];
        end
        chk("model_outClock", {28'd0, outClock}, {28'd0, eo});
        chk("model_tick", {28'd0, tick}, {28'd0, et});
        chk("model_pending", {28'd0, pending}, {28'd0, ep});
        syncIn   = 1'b0;
        cfgValid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic r;
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, r);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge inClock);
        #1;
        chk("reset_outClock", {28'd0, outClock}, 32'd0);
        chk("reset_tick", {28'd0, tick}, 32'd0);
        chk("reset_pending", {28'd0, pending}, 32'd0);
        chk("reset_cfgReady", {31'd0, cfgReady}, 32'd1);
        reset = 1'b0;
    endtask

    task automatic wait_clear(input int ch, input string name);
        int n;
        n = 0;
        while (pending[ch] && n < 40) begin
            idle(1);
            n++;
        end
        chk(name, {31'd0, pending[ch]}, 32'd0);
    endtask

`ifdef CLKDIV_DUTY_EN
    task automatic duty_run(input int dv, input int hi, input int exp_high);
        logic r;
        int   hc;
        wait_clear(0, "duty_idle");
        cycle(0, 1, 0, dv, hi, r);
        wait_clear(0, "duty_apply");
        hc = int'(outClock[0]);
        for (int k = 1; k < dv; k++) begin
            idle(1);
            hc += int'(outClock[0]);
        end
        chk("duty_high_cycles", hc, exp_high);
    endtask
`endif

    initial begin
        logic r;
        reset      = 1'b1;
        syncIn     = 1'b0;
        cfgValid   = 1'b0;
        cfgChannel = '0;
        cfgDivider = '0;
        cfgHigh    = '0;

        //          v  div rdy o  t  p   (channel 0, state after each edge)
        vecs[0]  = '{0, 0, 1, 0, 0, 0};
        vecs[1]  = '{0, 0, 1, 0, 0, 0};
        vecs[2]  = '{0, 0, 1, 0, 0, 0};
        vecs[3]  = '{0, 0, 1, 1, 1, 0};
        vecs[4]  = '{0, 0, 1, 1, 0, 0};
        vecs[5]  = '{0, 0, 1, 0, 0, 0};
        vecs[6]  = '{0, 0, 1, 0, 0, 0};
        vecs[7]  = '{0, 0, 1, 1, 1, 0};
        vecs[8]  = '{0, 0, 1, 1, 0, 0};
        vecs[9]  = '{1, 6, 1, 0, 0, 1};
        vecs[10] = '{1, 3, 0, 0, 0, 1};
        vecs[11] = '{1, 3, 0, 1, 1, 0};
        vecs[12] = '{1, 3, 1, 1, 0, 1};
        vecs[13] = '{0, 0, 0, 1, 0, 1};
        vecs[14] = '{0, 0, 0, 0, 0, 1};
        vecs[15] = '{0, 0, 0, 0, 0, 1};
        vecs[16] = '{0, 0, 0, 0, 0, 1};
        vecs[17] = '{0, 0, 0, 1, 1, 0};
        vecs[18] = '{0, 0, 1, 1, 0, 0};
        vecs[19] = '{0, 0, 1, 0, 0, 0};
        vecs[20] = '{0, 0, 1, 1, 1, 0};

        do_reset();

        for (int k = 0; k < 21; k++) begin
            cycle(0, vecs[k].v, 0, vecs[k].div, (vecs[k].div > 0) ? (vecs[k].div - 1) / 2 + 1 : 1, r);
            chk($sformatf("vec%0d_ready", k), {31'd0, r}, {31'd0, vecs[k].rdy});
            chk($sformatf("vec%0d_out", k), {31'd0, outClock[0]}, {31'd0, vecs[k].o});
            chk($sformatf("vec%0d_tick", k), {31'd0, tick[0]}, {31'd0, vecs[k].t});
            chk($sformatf("vec%0d_pend", k), {31'd0, pending[0]}, {31'd0, vecs[k].p});
        end

        // Two free-running channels with different periods, then a sync pulse.
        cycle(0, 1, 1, 5, 3, r);
        cycle(0, 1, 2, 7, 4, r);
        idle(13);
        cycle(1, 0, 0, 0, 0, r);
        chk("sync_tick", {30'd0, tick[2:1]}, 32'd3);
        chk("sync_out", {30'd0, outClock[2:1]}, 32'd3);
        idle(1);
        chk("sync_tick_after", {30'd0, tick[2:1]}, 32'd0);

        // Stop channel 3, then restart it with a divisor that clamps to 2.
        cycle(0, 1, 3, 0, 0, r);
        wait_clear(3, "stop_apply");
        for (int k = 0; k < 5; k++) begin
            idle(1);
            chk("stopped_out", {31'd0, outClock[3]}, 32'd0);
            chk("stopped_tick", {31'd0, tick[3]}, 32'd0);
        end
        cycle(0, 1, 3, 1, 1, r);
        chk("restart_wait_out", {31'd0, outClock[3]}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("clamp2_out", {31'd0, outClock[3]}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("clamp2_tick", {31'd0, tick[3]}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end

`ifdef CLKDIV_DUTY_EN
        duty_run(8, 3, 3);
        duty_run(8, 0, 1);
        duty_run(8, 9, 7);
`endif

        // Randomised traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom % 16) == 0, ($urandom % 3) == 0, int'($urandom % NUM_CH),
                  int'($urandom_range(0, 9)), int'($urandom_range(0, 10)), r);
        end

        // Reset mid-period discards a pending update.
        do_reset();
        cycle(0, 1, 0, 9, 5, r);
        chk("midrst_pending_set", {31'd0, pending[0]}, 32'd1);
        idle(1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_async_pending", {28'd0, pending}, 32'd0);
        chk("midrst_async_out", {28'd0, outClock}, 32'd0);
        do_reset();
        for (int k = 1; k <= RESET_DIV; k++) begin
            idle(1);
            chk("midrst_first_tick", {31'd0, tick[0]}, (k == RESET_DIV) ? 32'd1 : 32'd0);
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter DIV_W, default 8: divisor/counter width in bits; max divisor 2^DIV_W-1.
REQ-003 Parameter RESET_DIV, default 4: divisor loaded into every channel at reset.
REQ-004 inClock  input  1  source clock; all state on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 syncIn  input  1  one-cycle pulse; phase-aligns all running channels.
REQ-007 cfgValid  input  1  configuration request valid.
REQ-008 cfgReady  output  1  configuration request can be accepted this cycle.
REQ-009 cfgChannel  input  $clog2(NUM_CH) (min 1)  target channel index.
REQ-010 cfgDivider  input  DIV_W  new divisor; 0 = stop channel.
REQ-011 cfgHigh  input  DIV_W  high-time in cycles; present only with CLKDIV_DUTY_EN.
REQ-012 outClock  output  NUM_CH  registered divided clocks.
REQ-013 tick  output  NUM_CH  one-cycle pulse per channel at period start.
REQ-014 pending  output  NUM_CH  channel holds an accepted, not-yet-applied update.

Function
REQ-015 Each channel SHALL hold active divisor D, counter C (0..D-1), pending divisor P and pending flag.
REQ-016 Running channel (D>=2): C==D-1 -> C<=0, outClock<=1, tick<=1; else C<=C+1, tick<=0, outClock<=0 when C==H-1.
REQ-017 Default high-time H SHALL be floor((D-1)/2)+1 (D=4: 2 high/2 low; D=5: 3 high/2 low).
REQ-018 Divisor 1 SHALL be clamped to 2 on acceptance; divisor 0 stops the channel: C<=0, outClock<=0, tick<=0.
REQ-019 Handshake: transfer when cfgValid && cfgReady; cfgReady = !pending[cfgChannel]; cfgValid SHALL NOT be required to stay high.
REQ-020 Accepted update SHALL set pending; applied on the edge where the channel wraps (C==D-1), so no truncated or stretched period is produced; pending clears that edge.
REQ-021 Update to a stopped channel SHALL apply on the next edge; channel then starts at C=0, outClock=1, tick=1.
REQ-022 syncIn SHALL force every running channel to C<=0, outClock<=1, tick<=1 and apply any pending update already registered before that edge.
REQ-023 Update accepted on the same edge as syncIn or a wrap SHALL remain pending until the following wrap.
REQ-024 syncIn coincident with a natural wrap SHALL yield the same result as the wrap alone (one tick).
REQ-025 cfgChannel >= NUM_CH SHALL be accepted (cfgReady=1) and discarded.

Reset
REQ-026 On reset: C=0, D=RESET_DIV (clamped per REQ-018), H default, outClock=0, tick=0, pending=0, cfgReady=1.
REQ-027 Reset asserted mid-period SHALL discard pending updates; first tick occurs RESET_DIV cycles after deassertion.

Configuration
REQ-028 Macro CLKDIV_DUTY_EN defined: cfgHigh port exists; H stored per channel, loaded with the divisor; H=0 clamps to 1, H>=D clamps to D-1.
REQ-029 Macro CLKDIV_DUTY_EN undefined: no cfgHigh port, no H storage; H per REQ-017.

Structure
REQ-030 Package clkdiv_pkg SHALL hold DIV_W default, the channel-index width function, and the clamp rule constants.
REQ-031 Sub-module clkdiv_channel SHALL implement one channel (REQ-015..024), instantiated NUM_CH times by generate.

Verification
REQ-032 Reset release, RESET_DIV=4 -> every outClock 1100 repeating, tick every 4th cycle, first tick 4 cycles after release.
REQ-033 Ch0 running D=4, write D=6 at C=1 -> pending[0]=1 until wrap, one full 4-cycle period, then 6-cycle periods (3 high).
REQ-034 Second write to ch0 while pending -> cfgReady=0; request held until wrap, then accepted.
REQ-035 Ch1 D=5, ch2 D=7 free-running, syncIn pulse -> both tick together next cycle, outClock 1 on both.
REQ-036 Write D=0 then D=1 to ch3 -> outClock[3] held low; then 2-cycle period 10 (clamped).
REQ-037 CLKDIV_DUTY_EN, D=8 H=3 -> 3 high/5 low; H=0 -> 1 high; H=9 -> 7 high.
